// File: rtl/dma_in_stream_rx_pkg.sv
// dma_in_pkg: shared widths, FIFO entry layout and keep decode for the DMA input stream path
package dma_in_pkg;
  localparam int BYTES_PER_WORD = 4;
  localparam int IN_WIDTH = 32;
  localparam int NB_W = 3;
  typedef struct packed {
    logic [IN_WIDTH-1:0] data;
    logic [NB_W-1:0]     nbytes;
    logic                last;
  } entry_t;
  localparam int ENTRY_W = $bits(entry_t);
  typedef struct packed {
    logic            legal;
    logic [NB_W-1:0] nbytes;
  } keep_dec_t;
  function automatic keep_dec_t keep_decode(input logic [BYTES_PER_WORD-1:0] keep);
    keep_dec_t r;
    r.legal = 1'b1;
    r.nbytes = 3'd4;
    case (keep)
      4'b0001: r.nbytes = 3'd1;
      4'b0011: r.nbytes = 3'd2;
      4'b0111: r.nbytes = 3'd3;
      4'b1111: r.nbytes = 3'd4;
      default: r.legal = 1'b0;
    endcase
    return r;
  endfunction
endpackage

// File: rtl/dma_in_stream_rx_if.sv
// dma_in_stream_rx_if: word-in / byte-out stream handshake bundle
interface dma_in_stream_rx_if;
  import dma_in_pkg::*;
  logic [IN_WIDTH-1:0]       s_tdata_i;
  logic [BYTES_PER_WORD-1:0] s_tkeep_i;
  logic                      s_tlast_i;
  logic                      s_tvalid_i;
  logic                      s_tready_o;
  logic [7:0]                m_data_o;
  logic                      m_last_o;
  logic                      m_valid_o;
  logic                      m_ready_i;
  modport slave (
    input  s_tdata_i, s_tkeep_i, s_tlast_i, s_tvalid_i, m_ready_i,
    output s_tready_o, m_data_o, m_last_o, m_valid_o
  );
  modport master (
    output s_tdata_i, s_tkeep_i, s_tlast_i, s_tvalid_i, m_ready_i,
    input  s_tready_o, m_data_o, m_last_o, m_valid_o
  );
endinterface

// File: rtl/dma_in_stream_rx_fifo.sv
// dma_in_word_fifo: generic synchronous first-word-fall-through FIFO with count, registered ready and prog_full
module dma_in_word_fifo #(
  parameter int DEPTH = 16,
  parameter int W = 36,
  parameter int PROG_FULL_ASSERT = 12,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic         clk_i,
  input  logic         a_rstn_i,
  input  logic         clr_i,
  input  logic         wr_i,
  input  logic [W-1:0] wr_data_i,
  input  logic         rd_i,
  output logic [W-1:0] rd_data_o,
  output logic [AW:0]  count_o,
  output logic         empty_o,
  output logic         ready_o,
  output logic         prog_full_o
);
  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          ready_q, ready_d, pf_q, pf_d, do_wr, do_rd;
  // next pointers/count; clear wins over any push or pop in the same cycle
  always_comb begin
    do_wr = wr_i && count_q != (AW+1)'(DEPTH) && !clr_i;
    do_rd = rd_i && count_q != '0 && !clr_i;
    wr_ptr_d = clr_i ? '0 : wr_ptr_q + AW'(do_wr);
    rd_ptr_d = clr_i ? '0 : rd_ptr_q + AW'(do_rd);
    count_d = clr_i ? '0 : count_q + (AW+1)'(do_wr) - (AW+1)'(do_rd);
    ready_d = !clr_i && count_d != (AW+1)'(DEPTH);
    pf_d = count_d >= (AW+1)'(PROG_FULL_ASSERT);
  end
  // control state register
  always_ff @(posedge clk_i or negedge a_rstn_i) begin
    if (!a_rstn_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q <= '0;
      ready_q <= 1'b0;
      pf_q <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q <= count_d;
      ready_q <= ready_d;
      pf_q <= pf_d;
    end
  end
  // storage array, no reset needed since count gates every read
  always_ff @(posedge clk_i) begin
    if (do_wr) mem_q[wr_ptr_q] <= wr_data_i;
  end
  assign rd_data_o = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign empty_o = count_q == '0;
  assign ready_o = ready_q;
  assign prog_full_o = pf_q;
endmodule

// File: rtl/dma_in_stream_rx.sv
// dma_in_stream_rx: buffers 32-bit DMA words and unpacks them little-endian into a framed byte stream
module dma_in_stream_rx
  import dma_in_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int PROG_FULL_ASSERT = 12,
  parameter int FRAME_CNT_W = 16
) (
  input  logic                     clk_i,
  input  logic                     a_rstn_i,
  input  logic                     flush_i,
  dma_in_stream_rx_if.slave        bus,
  output logic [$clog2(DEPTH):0]   word_count_o,
  output logic                     prog_full_o,
  output logic                     frame_done_o,
  output logic [FRAME_CNT_W-1:0]   frame_len_o,
  output logic                     err_keep_o
);
  keep_dec_t              kd;
  entry_t                 wr_e, rd_e;
  logic                   push, empty, fifo_ready, acc, last_byte, last_out, pop;
  logic [1:0]             idx_q, idx_d;
  logic [FRAME_CNT_W-1:0] cnt_q, cnt_d, len_q, len_d, cnt_inc;
  logic                   done_q, done_d, err_q, err_d;
  dma_in_word_fifo #(.DEPTH(DEPTH), .W(ENTRY_W), .PROG_FULL_ASSERT(PROG_FULL_ASSERT)) u_fifo (
    .clk_i(clk_i), .a_rstn_i(a_rstn_i), .clr_i(flush_i),
    .wr_i(push), .wr_data_i(wr_e), .rd_i(pop), .rd_data_o(rd_e),
    .count_o(word_count_o), .empty_o(empty), .ready_o(fifo_ready), .prog_full_o(prog_full_o)
  );
  // keep decode, byte selection and next state of unpacker, frame counter and error flag
  always_comb begin
    kd = keep_decode(bus.s_tkeep_i);
    wr_e = {bus.s_tdata_i, kd.nbytes, bus.s_tlast_i};
    push = bus.s_tvalid_i && fifo_ready && !flush_i;
    last_byte = {1'b0, idx_q} == rd_e.nbytes - 3'd1;
    last_out = !empty && rd_e.last && last_byte;
    acc = !empty && bus.m_ready_i;
    pop = acc && last_byte;
    cnt_inc = &cnt_q ? cnt_q : cnt_q + FRAME_CNT_W'(1);
    idx_d = flush_i ? 2'd0 : !acc ? idx_q : last_byte ? 2'd0 : idx_q + 2'd1;
    cnt_d = flush_i ? '0 : !acc ? cnt_q : last_out ? '0 : cnt_inc;
    len_d = !flush_i && acc && last_out ? cnt_inc : len_q;
    done_d = !flush_i && acc && last_out;
    err_d = !flush_i && (err_q || (push && !kd.legal));
  end
  // unpacker, frame and error state register
  always_ff @(posedge clk_i or negedge a_rstn_i) begin
    if (!a_rstn_i) begin
      idx_q <= 2'd0;
      cnt_q <= '0;
      len_q <= '0;
      done_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      idx_q <= idx_d;
      cnt_q <= cnt_d;
      len_q <= len_d;
      done_q <= done_d;
      err_q <= err_d;
    end
  end
  assign bus.s_tready_o = fifo_ready;
  assign bus.m_valid_o = !empty;
  assign bus.m_data_o = empty ? 8'h00 : rd_e.data[{idx_q, 3'b000} +: 8];
  assign bus.m_last_o = last_out;
  assign frame_done_o = done_q;
  assign frame_len_o = len_q;
  assign err_keep_o = err_q;
endmodule

// File: tb/tb_dma_in_stream_rx.sv
// tb_dma_in_stream_rx: scoreboard bench for the word-to-byte DMA input stream buffer
module tb_dma_in_stream_rx;
  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        flush = 1'b0;
  logic [4:0]  word_count;
  logic        prog_full, frame_done, err_keep;
  logic [15:0] frame_len;
  int          checks = 0;
  int          errors = 0;
  int          run_len = 0;
  logic [8:0]  exp_q[$];
  int          len_q[$];
  logic [8:0]  mon_e;
  int          mon_l;

  dma_in_stream_rx_if bus();

  dma_in_stream_rx #(.DEPTH(16), .PROG_FULL_ASSERT(12), .FRAME_CNT_W(16)) dut (
    .clk_i(clk), .a_rstn_i(rst_n), .flush_i(flush), .bus(bus),
    .word_count_o(word_count), .prog_full_o(prog_full), .frame_done_o(frame_done),
    .frame_len_o(frame_len), .err_keep_o(err_keep)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // monitor: byte stream and frame-length pulses against the scoreboard queues
  always @(negedge clk) begin
    if (rst_n && bus.m_valid_o && bus.m_ready_i) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_byte: got %h expected none at %0t", bus.m_data_o, $time);
      end else begin
        mon_e = exp_q.pop_front();
        check("byte", {23'd0, bus.m_last_o, bus.m_data_o}, {23'd0, mon_e});
      end
    end
    if (rst_n && !bus.m_valid_o)
      check("idle_out", {23'd0, bus.m_last_o, bus.m_data_o}, 32'd0);
    if (rst_n && frame_done) begin
      if (len_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got len %0d expected none at %0t", frame_len, $time);
      end else begin
        mon_l = len_q.pop_front();
        check("frame_len", {16'd0, frame_len}, mon_l);
      end
    end
  end

  task automatic push_word(input logic [31:0] d, input logic [3:0] k, input logic l);
    int n;
    bit ok;
    ok = 1'b0;
    n = k == 4'b0001 ? 1 : k == 4'b0011 ? 2 : k == 4'b0111 ? 3 : 4;
    bus.s_tdata_i = d;
    bus.s_tkeep_i = k;
    bus.s_tlast_i = l;
    bus.s_tvalid_i = 1'b1;
    for (int t = 0; t < 200 && !ok; t++) begin
      @(negedge clk);
      ok = bus.s_tready_o;
      if (ok) begin
        for (int i = 0; i < n; i++) exp_q.push_back({l && i == n - 1, d[8*i +: 8]});
        run_len += n;
        if (l) begin
          len_q.push_back(run_len);
          run_len = 0;
        end
      end
      @(posedge clk);
      #1;
    end
    bus.s_tvalid_i = 1'b0;
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL push_timeout: got ready 0 expected 1 at %0t", $time);
    end
  endtask

  task automatic wait_drain();
    for (int t = 0; t < 300 && (exp_q.size() != 0 || len_q.size() != 0); t++) @(negedge clk);
    checks++;
    if (exp_q.size() != 0 || len_q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: got %0d bytes %0d frames left expected 0", exp_q.size(), len_q.size());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_tready"}, bus.s_tready_o, 0);
    check({tag, "_out"}, {bus.m_valid_o, bus.m_last_o, bus.m_data_o}, 0);
    check({tag, "_count"}, {prog_full, word_count}, 0);
    check({tag, "_status"}, {frame_done, err_keep, frame_len}, 0);
  endtask

  initial begin
    bus.s_tdata_i = '0;
    bus.s_tkeep_i = '0;
    bus.s_tlast_i = 1'b0;
    bus.s_tvalid_i = 1'b0;
    bus.m_ready_i = 1'b0;
    #1 rst_n = 1'b0;
    #1 check_reset_vals("reset");
    #20 rst_n = 1'b1;
    #1 check("tready_before_edge", bus.s_tready_o, 0);
    @(posedge clk);
    #1 check("tready_after_edge", bus.s_tready_o, 1);

    bus.m_ready_i = 1'b1;
    push_word(32'h44332211, 4'b1111, 1'b0);
    push_word(32'h88776655, 4'b1111, 1'b1);
    wait_drain();
    check("len8", frame_len, 8);

    push_word(32'h00CCBBAA, 4'b0111, 1'b1);
    wait_drain();
    check("len3", frame_len, 3);

    bus.m_ready_i = 1'b0;
    for (int i = 0; i < 16; i++) begin
      push_word({8'(4*i+3), 8'(4*i+2), 8'(4*i+1), 8'(4*i)}, 4'b1111, i == 15);
      if (i == 10) check("prog_full_11", prog_full, 0);
      if (i == 11) check("prog_full_12", prog_full, 1);
    end
    check("full_count", word_count, 16);
    check("full_tready", bus.s_tready_o, 0);
    bus.m_ready_i = 1'b1;
    for (int t = 0; t < 10 && !bus.s_tready_o; t++) @(negedge clk);
    check("ready_after_pop", bus.s_tready_o, 1);
    check("count_after_pop", word_count, 15);
    wait_drain();
    check("len64", frame_len, 64);

    push_word(32'hDDCCBBAA, 4'b0101, 1'b1);
    check("err_set", err_keep, 1);
    wait_drain();
    check("len_bad_keep", frame_len, 4);
    bus.m_ready_i = 1'b0;
    push_word(32'h12345678, 4'b1111, 1'b0);
    check("count_pre_flush", word_count, 1);
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    exp_q.delete();
    run_len = 0;
    check("flush_err", err_keep, 0);
    check("flush_count", word_count, 0);
    check("flush_valid", bus.m_valid_o, 0);
    check("flush_tready", bus.s_tready_o, 0);
    check("flush_len_kept", frame_len, 4);
    @(posedge clk);
    #1 check("tready_post_flush", bus.s_tready_o, 1);

    bus.m_ready_i = 1'b1;
    bus.s_tdata_i = 32'hCAFEF00D;
    bus.s_tkeep_i = 4'b1111;
    bus.s_tlast_i = 1'b1;
    bus.s_tvalid_i = 1'b1;
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    bus.s_tvalid_i = 1'b0;
    for (int t = 0; t < 3; t++) begin
      @(negedge clk);
      check("flush_drop_valid", bus.m_valid_o, 0);
    end
    check("flush_drop_count", word_count, 0);
    @(posedge clk);
    #1;

    bus.m_ready_i = 1'b0;
    for (int i = 0; i < 5; i++) push_word(32'h03020100 + 32'h04040404 * i, 4'b1111, 1'b0);
    check("mid_count", word_count, 5);
    bus.m_ready_i = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1 bus.m_ready_i = 1'b0;
    check("mid_data_idx2", bus.m_data_o, 8'h02);
    #2 rst_n = 1'b0;
    #1 check_reset_vals("async");
    exp_q.delete();
    len_q.delete();
    run_len = 0;
    #10 rst_n = 1'b1;
    @(posedge clk);
    #1 check("tready_rearm", bus.s_tready_o, 1);
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
